// File: rtl/alu_seq_nbit.sv
// Sequential N-bit ALU: single-cycle logic/arithmetic ops and a multi-cycle
// shift-add multiply behind a Start/Busy/Done handshake.
module alu_seq_nbit #(
  parameter int WIDTH = 24,
  parameter int CNTW  = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             CarryOut,
  output logic             Overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [1:0]         state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               zero_q, zero_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic               is_sub;
  logic               is_as;
  logic [WIDTH-1:0]   bx;
  logic [WIDTH:0]     sum;
  logic [CNTW-1:0]    shamt;
  logic               sh_big;
  logic [WIDTH-1:0]   exec_res;
  logic               exec_c;
  logic               exec_v;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] acc_step;

  assign is_sub = (op_q == OP_SUB);
  assign is_as  = (op_q == OP_ADD) || is_sub;
  assign bx     = is_sub ? ~b_q : b_q;
  assign sum    = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};
  assign shamt  = b_q[CNTW-1:0];
  assign sh_big = 32'(shamt) >= 32'(WIDTH);

  always_comb begin
    exec_res = '0;
    case (op_q)
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_ADD:  exec_res = sum[WIDTH-1:0];
      OP_SUB:  exec_res = sum[WIDTH-1:0];
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_NOR:  exec_res = ~(a_q | b_q);
      OP_SLT:  exec_res = {{(WIDTH-1){1'b0}},
                           $signed(a_q) < $signed(b_q)};
      OP_SLL:  exec_res = sh_big ? '0 : a_q << shamt;
      OP_SRL:  exec_res = sh_big ? '0 : a_q >> shamt;
      default: exec_res = '0;
    endcase
  end

  assign exec_c = is_as & sum[WIDTH];
  assign exec_v = is_as & (a_q[WIDTH-1] == bx[WIDTH-1])
                & (sum[WIDTH-1] != a_q[WIDTH-1]);

  // Low half of acc holds the multiplier and drains out as product bits enter.
  assign psum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + (acc_q[0] ? {1'b0, a_q} : '0);
  assign acc_step = {psum, acc_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d = ALUOp;
          a_d  = A;
          b_d  = B;
          if (ALUOp == OP_MUL) begin
            acc_d   = {{WIDTH{1'b0}}, B};
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        res_d   = exec_res;
        hi_d    = '0;
        zero_d  = (exec_res == '0);
        cout_d  = exec_c;
        ovf_d   = exec_v;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(WIDTH-1)) begin
          res_d   = acc_step[WIDTH-1:0];
          hi_d    = acc_step[2*WIDTH-1:WIDTH];
          zero_d  = (acc_step[WIDTH-1:0] == '0);
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign Busy     = (state_q != S_IDLE);
  assign Done     = done_q;
  assign Result   = res_q;
  assign ResultHi = hi_q;
  assign Zero     = zero_q;
  assign CarryOut = cout_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Scoreboard bench for alu_seq_nbit: expected results are queued at
// Start and popped when Done appears.
module tb_alu_seq_nbit;
  localparam int W = 24;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_BAD = 4'b1111;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         c;
    logic         v;
  } exp_t;

  typedef struct packed {
    logic [3:0]   f;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result, result_hi;
  logic         zero, cout, ovf;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_seq_nbit #(.WIDTH(W), .CNTW(5)) dut (
    .Clock(clk), .Reset(rst_n), .Start(start), .ALUOp(op),
    .A(a), .B(b), .Busy(busy), .Done(done), .Result(result),
    .ResultHi(result_hi), .Zero(zero), .CarryOut(cout),
    .Overflow(ovf)
  );

  function automatic exp_t model(input logic [3:0] f,
                                 input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    exp_t e;
    logic [W:0] s;
    logic [2*W-1:0] p;
    e = '0;
    case (f)
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_XOR: e.res = x ^ y;
      OP_NOR: e.res = ~(x | y);
      OP_ADD: begin
        s = {1'b0, x} + {1'b0, y};
        e.res = s[W-1:0];
        e.c = s[W];
        e.v = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
      end
      OP_SUB: begin
        e.res = x - y;
        e.c = (x >= y);
        e.v = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      OP_SLT: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      OP_SLL: e.res = (y[4:0] >= 5'd24) ? '0 : x << y[4:0];
      OP_SRL: e.res = (y[4:0] >= 5'd24) ? '0 : x >> y[4:0];
      OP_MUL: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e.res = p[W-1:0];
        e.hi = p[2*W-1:W];
      end
      default: e.res = '0;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Caller is at a negedge; returns 1 ns after the accepting edge.
  task automatic drive(input logic [3:0] f, input logic [W-1:0] x,
                       input logic [W-1:0] y);
    sb.push_back(model(f, x, y));
    start = 1'b1;
    op = f;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    op = 4'($urandom);
  endtask

  // Edges counted from the accepting edge up to the one raising Done.
  task automatic wait_done(output int edges);
    edges = 1;
    while (edges < 60) begin
      @(negedge clk);
      if (done === 1'b1) return;
      edges++;
    end
  endtask

  task automatic test_reset();
    logic [2*W+4:0] got, req;
    rst_n = 1'b0;
    start = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    req = {1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b1, 1'b0, 1'b0};
    got = {busy, done, result, result_hi, zero, cout, ovf};
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL reset_state got=%h req=%h", got, req);
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = {busy, done, result, result_hi, zero, cout, ovf};
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL reset_release got=%h req=%h", got, req);
    end
  endtask

  task automatic test_arith();
    vec_t tbl[5];
    int ed;
    exp_t e, g;
    tbl[0] = '{OP_ADD, 24'h000005, 24'h000003};
    tbl[1] = '{OP_ADD, 24'h7FFFFF, 24'h000001};
    tbl[2] = '{OP_SUB, 24'h000004, 24'h000004};
    tbl[3] = '{OP_ADD, 24'hFFFFFF, 24'h000001};
    tbl[4] = '{OP_SUB, 24'h800000, 24'h000001};
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].f, tbl[i].x, tbl[i].y);
      wait_done(ed);
      n_checks++;
      if (ed !== 2) begin
        n_fail++;
        $display("FAIL arith_latency[%0d] got=%0d req=2", i, ed);
      end
      e = sb.pop_front();
      g = {result, result_hi, zero, cout, ovf};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL arith_result[%0d] got=%h req=%h", i, g, e);
      end
    end
  endtask

  task automatic test_logic();
    vec_t tbl[10];
    int ed;
    exp_t e, g;
    tbl[0] = '{OP_SLT, 24'hFFFFFF, 24'h000001};
    tbl[1] = '{OP_SLT, 24'h000001, 24'hFFFFFF};
    tbl[2] = '{OP_NOR, 24'h000000, 24'h000000};
    tbl[3] = '{OP_SLL, 24'h000001, 24'd30};
    tbl[4] = '{OP_SLL, 24'h000001, 24'd23};
    tbl[5] = '{OP_SRL, 24'h800000, 24'd7};
    tbl[6] = '{OP_SRL, 24'hFFFFFF, 24'd24};
    tbl[7] = '{OP_OR,  24'h0F0F00, 24'h00F0F0};
    tbl[8] = '{OP_BAD, 24'h123456, 24'h654321};
    tbl[9] = '{OP_AND, 24'hF0F0F0, 24'h3C3C3C};
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].f, tbl[i].x, tbl[i].y);
      wait_done(ed);
      e = sb.pop_front();
      g = {result, result_hi, zero, cout, ovf};
      n_checks++;
      if (ed !== 2 || g !== e) begin
        n_fail++;
        $display("FAIL logic[%0d] got=%h lat=%0d req=%h lat=2",
                 i, g, ed, e);
      end
    end
  endtask

  task automatic test_mul();
    int nbusy, ndone, dedge;
    exp_t e, g;
    @(negedge clk);
    drive(OP_MUL, 24'hFFFFFF, 24'h000002);
    nbusy = 0;
    ndone = 0;
    dedge = -1;
    g = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 5) begin
        start = 1'b1;
        op = OP_ADD;
        a = 24'h000001;
        b = 24'h000001;
      end
      if (i == 6) start = 1'b0;
      if (busy === 1'b1) nbusy++;
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          dedge = i + 1;
          g = {result, result_hi, zero, cout, ovf};
        end
      end
    end
    n_checks++;
    if (nbusy !== 24) begin
      n_fail++;
      $display("FAIL mul_busy_cycles got=%0d req=24", nbusy);
    end
    n_checks++;
    if (ndone !== 1) begin
      n_fail++;
      $display("FAIL mul_done_pulses got=%0d req=1", ndone);
    end
    n_checks++;
    if (dedge !== 25) begin
      n_fail++;
      $display("FAIL mul_latency got=%0d req=25", dedge);
    end
    e = sb.pop_front();
    n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL mul_result got=%h req=%h", g, e);
    end
  endtask

  task automatic test_mul_reset();
    logic [2*W+4:0] got, req;
    int ndone, ed;
    exp_t e, g;
    @(negedge clk);
    drive(OP_MUL, 24'h001234, 24'h000010);
    for (int i = 0; i < 10; i++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    req = {1'b0, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b1, 1'b0, 1'b0};
    got = {busy, done, result, result_hi, zero, cout, ovf};
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL mul_abort_state got=%h req=%h", got, req);
    end
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin
      n_fail++;
      $display("FAIL mul_abort_no_done got=%0d req=0", ndone);
    end
    @(negedge clk);
    drive(OP_ADD, 24'h000005, 24'h000003);
    wait_done(ed);
    e = sb.pop_front();
    g = {result, result_hi, zero, cout, ovf};
    n_checks++;
    if (ed !== 2 || g !== e) begin
      n_fail++;
      $display("FAIL post_abort_add got=%h lat=%0d req=%h lat=2",
               g, ed, e);
    end
    @(negedge clk);
    drive(OP_MUL, 24'h001234, 24'h000010);
    wait_done(ed);
    e = sb.pop_front();
    g = {result, result_hi, zero, cout, ovf};
    n_checks++;
    if (ed !== 25 || g !== e) begin
      n_fail++;
      $display("FAIL post_abort_mul got=%h lat=%0d req=%h lat=25",
               g, ed, e);
    end
  endtask

  task automatic test_back_to_back();
    int ed;
    exp_t e, g;
    @(negedge clk);
    drive(OP_XOR, 24'hAAAAAA, 24'hFFFFFF);
    wait_done(ed);
    e = sb.pop_front();
    g = {result, result_hi, zero, cout, ovf};
    n_checks++;
    if (ed !== 2 || g !== e) begin
      n_fail++;
      $display("FAIL b2b_xor got=%h lat=%0d req=%h lat=2", g, ed, e);
    end
    drive(OP_AND, 24'hAAAAAA, 24'hFFFFFF);
    wait_done(ed);
    e = sb.pop_front();
    g = {result, result_hi, zero, cout, ovf};
    n_checks++;
    if (ed !== 2 || g !== e) begin
      n_fail++;
      $display("FAIL b2b_and got=%h gap=%0d req=%h gap=2", g, ed, e);
    end
  endtask

  task automatic test_random();
    logic [3:0] ops[10];
    logic [3:0] f;
    logic [W-1:0] x, y;
    int ed;
    exp_t e, g;
    ops = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB,
            OP_SLT, OP_MUL, OP_SLL, OP_SRL, OP_NOR};
    for (int i = 0; i < 16; i++) begin
      f = ops[$urandom_range(0, 9)];
      x = W'($urandom);
      y = W'($urandom);
      if (f == OP_SLL || f == OP_SRL) y = W'($urandom_range(0, 31));
      @(negedge clk);
      drive(f, x, y);
      wait_done(ed);
      e = sb.pop_front();
      g = {result, result_hi, zero, cout, ovf};
      n_checks++;
      if (ed !== ((f == OP_MUL) ? 25 : 2) || g !== e) begin
        n_fail++;
        $display("FAIL random[%0d] op=%b a=%h b=%h got=%h lat=%0d req=%h",
                 i, f, x, y, g, ed, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_mul();
    test_mul_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_nbit.md
Name: alu_seq_nbit

Overview:
- Parametrised sequential ALU; successor to the 1-bit ALU slice. Operates on WIDTH-bit operands with registered results and status flags.
- Single-cycle logic/arithmetic ops plus a multi-cycle shift-add multiply, under a Start/Busy/Done handshake.
- Sits between the register file read ports and the writeback mux of the 24-bit single-cycle CPU datapath. The control unit stalls on Busy.

Parameters:
- WIDTH, 24, operand/result width in bits (≥2).
- CNTW, 5, width of multiply iteration counter; must satisfy 2^CNTW ≥ WIDTH.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only when Busy=0.
- ALUOp  input  4  operation select (encoding below).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Busy  output  1  high while an op is in progress.
- Done  output  1  one-cycle pulse: Result/flags updated this cycle.
- Result  output  WIDTH  registered result (low half for MUL).
- ResultHi  output  WIDTH  MUL high half; 0 for all other ops.
- Zero  output  1  Result == 0.
- CarryOut  output  1  carry out of MSB for ADD/SUB; else 0.
- Overflow  output  1  signed overflow for ADD/SUB; else 0.

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; Busy=0, Done=0, Result=0, ResultHi=0, Zero=1, CarryOut=0, Overflow=0, counter=0.
- ALUOp encoding:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB (A + ~B + 1); 0111 SLT (signed; Result = {0…,A<B}).
  - 1100 NOR; 0011 XOR.
  - 1000 MUL (unsigned, multi-cycle).
  - 1001 SLL by B[CNTW-1:0]; 1010 SRL by B[CNTW-1:0]. Shift amount ≥ WIDTH gives 0.
  - Any other code gives Result=0.
- States: IDLE, EXEC, MUL.
- Operands and ALUOp are captured into internal registers on the accepting edge. Changes to the A, B or ALUOp inputs after that edge have no effect.
- IDLE, Start=1, ALUOp≠MUL → EXEC.
  - Busy=1 for one cycle; on the next edge, Result, flags and Done=1 are written; return to IDLE.
  - Latency from Start to Done is 2 edges.
  - Busy is combinational from state (not from Start).
- IDLE, Start=1, ALUOp=MUL → MUL.
  - Load multiplicand, multiplier and a 2·WIDTH accumulator; counter=0.
  - Each cycle: if multiplier LSB=1, add multiplicand into the upper half; then shift right one bit; counter+1.
  - After WIDTH iterations: write Result=product[WIDTH-1:0], ResultHi=product[2W-1:W]; Done=1; go to IDLE.
  - Busy=1 for exactly WIDTH cycles.
- Start while Busy=1 is ignored: no queuing, no error.
- Start asserted in the Done cycle (state IDLE) is accepted: back-to-back ops are permitted.
- Done is high exactly one cycle per accepted op. Result and flags hold their values until the next Done.
- Flags are written only at Done, from the final Result:
  - Zero = (Result == 0), including for MUL, where it covers the low half only.
  - CarryOut/Overflow are computed on the WIDTH+1-bit sum: Overflow = (sign A' == sign B') && (sign sum ≠ sign A'), where B' = ~B for SUB.
- Reset asserted mid-MUL aborts immediately to the reset values. No Done is produced for the aborted op.

Test Plan:
- Reset then release; ADD A=0x000005, B=0x000003 → Done on 2nd edge after Start; Result=0x000008, Zero=0, CarryOut=0, Overflow=0.
- ADD A=0x7FFFFF, B=0x000001 → Result=0x800000, Overflow=1, CarryOut=0. SUB A=0x000004, B=0x000004 → Result=0, Zero=1, CarryOut=1.
- SLT A=0xFFFFFF (−1), B=0x000001 → Result=0x000001. NOR A=0, B=0 → Result=0xFFFFFF. SLL A=1, B=30 → Result=0.
- MUL A=0xFFFFFF, B=0x000002 → Busy high exactly 24 cycles; Result=0xFFFFFE, ResultHi=0x000001, Done one pulse. A second Start pulsed mid-op is ignored.
- MUL A=0x001234, B=0x000010; assert Reset at iteration 10 → all outputs return to reset values immediately. No Done follows, and the next ADD completes normally.
- Back-to-back: Start XOR (A=0xAAAAAA, B=0xFFFFFF), then Start AND in the Done cycle → Results 0x555555, then 0xAAAAAA, on consecutive Done pulses two cycles apart.
